// File: rtl/nabp_image_ram_writer.sv
// Image-RAM writer: buffers PE pixel values in a small FIFO and streams them to the
// image RAM at consecutive raster addresses, honouring ir_enable back-pressure.
module nabp_image_ram_writer #(
   parameter int ADDR_W     = 12,
   parameter int DATA_W     = 8,
   parameter int IMG_W      = 64,
   parameter int IMG_H      = 64,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   output logic              busy,
   input  logic              pe_valid,
   input  logic [DATA_W-1:0] pe_val,
   output logic              pe_ready,
   output logic              ir_kick,
   output logic [ADDR_W-1:0] ir_addr,
   output logic [DATA_W-1:0] ir_val,
   output logic              ir_done,
   input  logic              ir_enable
);

   localparam int LP_CW = ADDR_W + 1;
   localparam int LP_PW = $clog2(FIFO_DEPTH);
   localparam logic [LP_CW-1:0] LP_NPIX = LP_CW'(IMG_W * IMG_H);
   localparam logic [LP_CW-1:0] LP_LAST = LP_CW'(IMG_W * IMG_H - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_STREAM,
      S_DONE
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
   logic [LP_PW:0]    r_wptr;
   logic [LP_PW:0]    r_rptr;
   logic [LP_CW-1:0]  r_addr;
   logic [LP_CW-1:0]  r_acc;
   logic              w_empty;
   logic              w_full;
   logic              w_push;
   logic              w_pop;
   logic              w_start;
   logic              w_clear;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign w_empty = (r_wptr == r_rptr);
   assign w_full  = (r_wptr[LP_PW] != r_rptr[LP_PW]) &&
                    (r_wptr[LP_PW-1:0] == r_rptr[LP_PW-1:0]);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      busy        = 1'b0;
      pe_ready    = 1'b0;
      ir_kick     = 1'b0;
      ir_done     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nxt = S_STREAM;
            end
         end
         S_STREAM: begin
            busy     = 1'b1;
            pe_ready = !w_full && (r_acc < LP_NPIX);
            ir_kick  = !w_empty;
            if (!w_empty && ir_enable && (r_addr == LP_LAST)) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            busy        = 1'b1;
            ir_done     = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign w_push  = pe_valid & pe_ready;
   assign w_pop   = ir_kick & ir_enable;
   assign w_start = (r_state == S_IDLE) & start;
   assign w_clear = w_start | (r_state == S_DONE);

   assign ir_addr = r_addr[ADDR_W-1:0];
   assign ir_val  = ir_kick ? r_mem[r_rptr[LP_PW-1:0]] : '0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_addr <= '0;
         r_acc  <= '0;
      end else if (w_clear) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_addr <= '0;
         r_acc  <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + 1'b1;
            r_acc  <= r_acc + 1'b1;
         end
         if (w_pop) begin
            r_rptr <= r_rptr + 1'b1;
            r_addr <= r_addr + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wptr[LP_PW-1:0]] <= pe_val;
      end
   end

endmodule

// File: tb/tb_nabp_image_ram_writer.sv
// Bench for nabp_image_ram_writer: directed frames plus random traffic, checked cycle by
// cycle against a queue-based model of the writer's behaviour.
module tb_nabp_image_ram_writer;

   localparam int AW   = 12;
   localparam int DW   = 8;
   localparam int W    = 4;
   localparam int H    = 2;
   localparam int D    = 4;
   localparam int NPIX = W * H;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          start;
   logic          busy;
   logic          pe_valid;
   logic [DW-1:0] pe_val;
   logic          pe_ready;
   logic          ir_kick;
   logic [AW-1:0] ir_addr;
   logic [DW-1:0] ir_val;
   logic          ir_done;
   logic          ir_enable;

   always #5 clk = ~clk;

   nabp_image_ram_writer #(
      .ADDR_W    (AW),
      .DATA_W    (DW),
      .IMG_W     (W),
      .IMG_H     (H),
      .FIFO_DEPTH(D)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .start    (start),
      .busy     (busy),
      .pe_valid (pe_valid),
      .pe_val   (pe_val),
      .pe_ready (pe_ready),
      .ir_kick  (ir_kick),
      .ir_addr  (ir_addr),
      .ir_val   (ir_val),
      .ir_done  (ir_done),
      .ir_enable(ir_enable)
   );

   int n_cmp = 0;
   int n_err = 0;

   // Model: frame phase flags, pending words in arrival order, transfer/accept counts.
   bit            m_active;
   bit            m_done;
   int            m_addr;
   int            m_acc;
   logic [DW-1:0] m_q[$];
   int            m_frames = 0;
   int            dut_frames = 0;
   bit            inc_mode;
   logic [DW-1:0] last_val;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic model_reset();
      m_active = 1'b0;
      m_done   = 1'b0;
      m_addr   = 0;
      m_acc    = 0;
      m_q.delete();
   endtask

   function automatic bit exp_ready();
      return m_active && (m_q.size() < D) && (m_acc < NPIX);
   endfunction

   function automatic bit exp_kick();
      return m_active && (m_q.size() > 0);
   endfunction

   task automatic cycle();
      bit ep, ek, push, pop;
      @(negedge clk);
      ek = exp_kick();
      ep = exp_ready();
      chk("busy", busy, m_active || m_done);
      chk("pe_ready", pe_ready, ep);
      chk("ir_kick", ir_kick, ek);
      chk("ir_done", ir_done, m_done);
      if (ek) begin
         chk("ir_addr", ir_addr, m_addr);
         chk("ir_val", ir_val, m_q[0]);
      end else if (!m_active && !m_done) begin
         chk("ir_addr_idle", ir_addr, 0);
      end
      if (ir_done) dut_frames++;
      if (ir_kick && ir_enable && ir_addr == AW'(NPIX - 1)) last_val = ir_val;
      push = ep && pe_valid;
      pop  = ek && ir_enable;
      @(posedge clk);
      if (!reset_n) begin
         model_reset();
      end else if (m_active) begin
         if (pop) begin
            void'(m_q.pop_front());
            m_addr++;
            if (m_addr == NPIX) begin
               m_active = 1'b0;
               m_done   = 1'b1;
               m_frames++;
            end
         end
         if (push) begin
            m_q.push_back(pe_val);
            m_acc++;
         end
      end else if (m_done) begin
         m_done = 1'b0;
         m_addr = 0;
         m_acc  = 0;
      end else if (start) begin
         m_active = 1'b1;
         m_addr   = 0;
         m_acc    = 0;
         m_q.delete();
      end
      #1;
      if (inc_mode && push) pe_val = pe_val + 1'b1;
   endtask

   task automatic run_to_idle(input string tag);
      for (int k = 0; k < 100; k++) begin
         if (!m_active && !m_done) break;
         cycle();
      end
      chk(tag, busy, 0);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      cycle();
      start = 1'b0;
   endtask

   initial begin
      int f0;
      reset_n   = 1'b0;
      start     = 1'b0;
      pe_valid  = 1'b0;
      pe_val    = '0;
      ir_enable = 1'b0;
      inc_mode  = 1'b0;
      last_val  = '0;
      model_reset();

      // Reset held, then released with no start.
      for (int k = 0; k < 3; k++) cycle();
      chk("rst_addr", ir_addr, 0);
      chk("rst_val", ir_val, 0);
      reset_n = 1'b1;
      for (int k = 0; k < 3; k++) cycle();

      // Back-to-back frame 10..17, pe_valid held after the last word.
      inc_mode  = 1'b1;
      pe_val    = 8'd10;
      pe_valid  = 1'b1;
      ir_enable = 1'b1;
      pulse_start();
      run_to_idle("frame_basic_end");
      chk("frame_basic_done", dut_frames, 1);
      chk("frame_basic_last", last_val, 17);

      // Mid-frame stall of six cycles.
      pe_val = 8'd40;
      pulse_start();
      cycle();
      cycle();
      ir_enable = 1'b0;
      for (int k = 0; k < 6; k++) cycle();
      chk("stall_ready", pe_ready, 0);
      chk("stall_kick", ir_kick, 1);
      ir_enable = 1'b1;
      run_to_idle("frame_stall_end");
      chk("frame_stall_last", last_val, 47);

      // start held through STREAM and the ir_done cycle; only the following one restarts.
      pe_val = 8'd70;
      f0     = m_frames;
      start  = 1'b1;
      for (int k = 0; k < 60; k++) begin
         cycle();
         if (m_frames == f0 + 1 && m_active) break;
      end
      start = 1'b0;
      chk("restart_busy", busy, 1);
      chk("restart_addr", ir_addr, 0);
      run_to_idle("frame_restart_end");
      chk("restart_frames", dut_frames, f0 + 2);

      // Asynchronous reset while the address counter sits at 3.
      pe_val = 8'd100;
      pulse_start();
      for (int k = 0; k < 20; k++) begin
         if (m_addr == 3) break;
         cycle();
      end
      chk("reached_addr3", ir_addr, 3);
      #2;
      reset_n = 1'b0;
      #1;
      model_reset();
      chk("arst_busy", busy, 0);
      chk("arst_ready", pe_ready, 0);
      chk("arst_kick", ir_kick, 0);
      chk("arst_addr", ir_addr, 0);
      chk("arst_val", ir_val, 0);
      chk("arst_done", ir_done, 0);
      cycle();
      cycle();
      reset_n = 1'b1;
      cycle();
      pe_val = 8'd120;
      pulse_start();
      run_to_idle("frame_postrst_end");
      chk("frame_postrst_last", last_val, 127);

      // Random traffic.
      inc_mode = 1'b0;
      for (int k = 0; k < 800; k++) begin
         pe_valid  = ($urandom_range(0, 3) != 0);
         ir_enable = ($urandom_range(0, 2) != 0);
         start     = ($urandom_range(0, 7) == 0);
         pe_val    = DW'($urandom);
         cycle();
      end
      start     = 1'b0;
      pe_valid  = 1'b1;
      ir_enable = 1'b1;
      run_to_idle("random_drain_end");
      chk("frames_total", dut_frames, m_frames);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
